// File: rtl/fetch_aligner.sv
// -----------------------------------------------------------------------------
// fetch_aligner
//
// Instruction-fetch front end feeding the IF/ID stage register. Whole 32-bit
// words are fetched from instruction memory over a req/ack handshake and kept
// as halfwords in a 4-entry buffer. One aligned instruction (16-bit compressed
// or 32-bit) is presented per cycle under valid/ready. Redirects may target any
// halfword; a fetch that is already in flight when a redirect arrives is allowed
// to complete (FLUSH state) and its data is discarded.
//
// Configuration macro: FETCH_RVC_EN
//   defined   : compressed (16-bit) instructions supported, halfword targets.
//   undefined : every instruction is 32-bit, targets/reset PC forced to word
//               alignment, inst_compressed tied low, two halfwords per consume.
//
// Parameters
//   ADDR_W    PC / memory address width
//   RESET_PC  first fetch PC after reset
//
// Ports
//   clk              clock, all state on rising edge
//   rst              synchronous active-low reset
//   mem_req          word fetch request (held until mem_ack)
//   mem_addr         word-aligned fetch address
//   mem_ack          mem_rdata valid, completes the request
//   mem_rdata        fetched word, halfword 0 in [15:0]
//   redirect         flush and restart at redirect_pc
//   redirect_pc      new PC (bit 0 ignored)
//   inst_valid       inst_out / inst_pc valid
//   out_ready        IF/ID register loads this cycle
//   inst_out         instruction, compressed ones zero-extended
//   inst_pc          PC of inst_out
//   inst_compressed  inst_out is a 16-bit instruction
// -----------------------------------------------------------------------------
module fetch_aligner #(
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              out_ready,
  output logic [31:0]       inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_compressed
);

`ifdef FETCH_RVC_EN
  localparam bit                RVC_EN  = 1'b1;
  localparam logic [ADDR_W-1:0] PC_MASK = ~ADDR_W'(1);
`else
  localparam bit                RVC_EN  = 1'b0;
  localparam logic [ADDR_W-1:0] PC_MASK = ~ADDR_W'(3);
`endif

  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] HEAD_RST  = RESET_PC & PC_MASK;
  localparam logic [ADDR_W-1:0] FETCH_RST = RESET_PC & WORD_MASK;
  localparam logic              SKIP_RST  = RVC_EN & RESET_PC[1];

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [2:0]          occ_q, occ_d;          // buffered halfwords, 0..4
  logic [ADDR_W-1:0]   head_pc_q, head_pc_d;  // PC of buffer entry 0
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;// next word to fetch
  logic [ADDR_W-1:0]   addr_q, addr_d;        // address of the open request
  logic                skip_q, skip_d;        // drop low half of next word
  logic                req_q, req_d;          // request open towards memory

  logic [15:0]         buf_view [4];          // entry 0 is the head

  // ---------------------------------------------------------------------------
  // Head decode and handshake terms
  // ---------------------------------------------------------------------------
  logic                in_run;
  logic                head_is16;
  logic                valid_w;
  logic                consume;
  logic                ack_take;
  logic                hold_req;
  logic                append;
  logic [1:0]          pop_n;
  logic [1:0]          app_n;
  logic [2:0]          occ_pop;
  logic [15:0]         lo_hw;
  logic [15:0]         hi_hw;
  logic [ADDR_W-1:0]   tgt_pc;
  logic [ADDR_W-1:0]   tgt_word;
  logic                tgt_skip;

  assign in_run = (state_q == S_RUN);

`ifdef FETCH_RVC_EN
  assign head_is16 = (buf_view[0][1:0] != 2'b11);
  assign tgt_skip  = redirect_pc[1];
`else
  assign head_is16 = 1'b0;
  assign tgt_skip  = 1'b0;
`endif

  assign tgt_pc   = redirect_pc & PC_MASK;
  assign tgt_word = redirect_pc & WORD_MASK;

  // A 32-bit instruction needs both of its halfwords buffered, which also
  // covers the case where it straddles two fetched words.
  assign valid_w  = in_run && ((occ_q >= 3'd1 && head_is16) || occ_q >= 3'd2);

  // Redirect wins over consume and append in the same cycle.
  assign consume  = valid_w && out_ready && !redirect;
  assign ack_take = req_q && mem_ack;
  assign hold_req = req_q && !mem_ack;
  assign append   = ack_take && in_run && !redirect;

  assign pop_n    = consume ? (head_is16 ? 2'd1 : 2'd2) : 2'd0;
  assign app_n    = append ? (skip_q ? 2'd1 : 2'd2) : 2'd0;
  assign occ_pop  = occ_q - {1'b0, pop_n};

  // After a redirect to an odd halfword only the upper half of the first word
  // belongs to the new stream.
  assign lo_hw    = skip_q ? mem_rdata[31:16] : mem_rdata[15:0];
  assign hi_hw    = mem_rdata[31:16];

  // ---------------------------------------------------------------------------
  // Halfword buffer: pop shifts entries down, appended halfwords land directly
  // behind whatever survives the pop, so consume and append can share a cycle.
  // ---------------------------------------------------------------------------
  logic [5:0][15:0] buf_ext;
  assign buf_ext = {32'h0, buf_view[3], buf_view[2], buf_view[1], buf_view[0]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_buf
      localparam logic [2:0] SLOT = 3'(gi);
      logic [15:0] entry_q, entry_d;
      logic [2:0]  src;

      assign src = SLOT + {1'b0, pop_n};

      always_comb begin
        entry_d = buf_ext[src];
        if (app_n != 2'd0 && occ_pop == SLOT) begin
          entry_d = lo_hw;
        end
        if (app_n == 2'd2 && (occ_pop + 3'd1) == SLOT) begin
          entry_d = hi_hw;
        end
      end

      always_ff @(posedge clk) begin
        if (!rst) begin
          entry_q <= '0;
        end else begin
          entry_q <= entry_d;
        end
      end

      assign buf_view[gi] = entry_q;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    occ_d      = occ_q;
    head_pc_d  = head_pc_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    skip_d     = skip_q;
    req_d      = req_q;

    unique case (state_q)
      S_RUN: begin
        if (redirect) begin
          occ_d      = 3'd0;
          head_pc_d  = tgt_pc;
          fetch_pc_d = tgt_word;
          skip_d     = tgt_skip;
          req_d      = 1'b1;
          if (hold_req) begin
            // The open request cannot be withdrawn; let it finish and
            // throw its data away.
            state_d = S_FLUSH;
            addr_d  = addr_q;
          end else begin
            addr_d  = tgt_word;
          end
        end else begin
          occ_d     = occ_pop + {1'b0, app_n};
          head_pc_d = head_pc_q + ADDR_W'({pop_n, 1'b0});
          if (append) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(4);
            skip_d     = 1'b0;
          end
          if (hold_req) begin
            req_d  = 1'b1;
            addr_d = addr_q;
          end else begin
            // Only ask for a word when both of its halfwords will fit.
            req_d  = (occ_d <= 3'd2);
            addr_d = fetch_pc_d;
          end
        end
      end

      S_FLUSH: begin
        if (redirect) begin
          head_pc_d  = tgt_pc;
          fetch_pc_d = tgt_word;
          skip_d     = tgt_skip;
        end
        req_d = 1'b1;
        if (ack_take || !req_q) begin
          state_d = S_RUN;
          addr_d  = fetch_pc_d;
        end
      end

      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_RUN;
      occ_q      <= 3'd0;
      head_pc_q  <= HEAD_RST;
      fetch_pc_q <= FETCH_RST;
      addr_q     <= FETCH_RST;
      skip_q     <= SKIP_RST;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      head_pc_q  <= head_pc_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      skip_q     <= skip_d;
      req_q      <= req_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (registered state only)
  // ---------------------------------------------------------------------------
  assign mem_req         = req_q;
  assign mem_addr        = addr_q;
  assign inst_valid      = valid_w;
  assign inst_pc         = head_pc_q;
  assign inst_compressed = valid_w && head_is16;

  always_comb begin
    inst_out = 32'h0;
    if (valid_w) begin
      inst_out = head_is16 ? {16'h0, buf_view[0]} : {buf_view[1], buf_view[0]};
    end
  end

endmodule

// File: tb/tb_fetch_aligner.sv
// -----------------------------------------------------------------------------
// tb_fetch_aligner
//
// Directed phases followed by a randomized phase. A behavioural memory image
// supplies fetched words with a configurable response latency; the expected
// instruction stream is derived by walking that image halfword by halfword from
// the current program counter, and the expected fetch address sequence is
// derived from the redirect history.
// -----------------------------------------------------------------------------
module tb_fetch_aligner;

`ifdef FETCH_RVC_EN
  localparam bit RVC = 1'b1;
`else
  localparam bit RVC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid;
  logic        out_ready = 1'b0;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_compressed;

  fetch_aligner dut (
    .clk             (clk),
    .rst             (rst),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .out_ready       (out_ready),
    .inst_out        (inst_out),
    .inst_pc         (inst_pc),
    .inst_compressed (inst_compressed)
  );

  always #5 clk = ~clk;

  logic [31:0] img [1024];

  int          total = 0;
  int          bad = 0;

  // reference state
  logic [31:0] mpc;        // PC of next instruction the pipeline should see
  logic [31:0] fetch_exp;  // address the next fresh request must carry
  int          epoch;      // bumps on every redirect / reset
  int          req_epoch;
  logic [31:0] req_addr;
  bit          pend;
  int          wcnt;
  int          minlat;
  int          maxlat;
  bit          exp_idle;
  int          accepted;

  function automatic logic [15:0] hw_at(input logic [31:0] a);
    logic [31:0] w;
    w = img[a[11:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  function automatic void model_inst(input logic [31:0] pc, output logic [31:0] inst,
                                     output logic comp, output int len);
    logic [15:0] h;
    if (RVC) begin
      h = hw_at(pc);
      if (h[1:0] != 2'b11) begin
        inst = {16'h0, h};
        comp = 1'b1;
        len  = 2;
      end else begin
        inst = {hw_at(pc + 32'd2), h};
        comp = 1'b0;
        len  = 4;
      end
    end else begin
      inst = img[pc[11:2]];
      comp = 1'b0;
      len  = 4;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_redirect(input logic [31:0] t);
    epoch++;
    fetch_exp = t & ~32'd3;
    mpc       = RVC ? (t & ~32'd1) : (t & ~32'd3);
  endtask

  // One clock cycle: called at a falling edge with redirect/out_ready already
  // set; plays the memory side, checks any accepted instruction, then advances.
  task automatic cycle();
    logic [31:0] e_inst;
    logic        e_c;
    int          len;
    if (exp_idle) chk("valid_after_redirect", {31'b0, inst_valid}, 32'd0);
    exp_idle = redirect;

    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    if (mem_req) begin
      if (!pend) begin
        chk("req_addr", mem_addr, fetch_exp);
        pend      = 1'b1;
        req_addr  = mem_addr;
        req_epoch = epoch;
        wcnt      = $urandom_range(maxlat, minlat);
      end else begin
        chk("req_hold", mem_addr, req_addr);
      end
      if (wcnt == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = img[mem_addr[11:2]];
      end else begin
        wcnt--;
      end
    end else if (pend) begin
      chk("req_withdrawn", {31'b0, mem_req}, 32'd1);
      pend = 1'b0;
    end

    if (inst_valid && out_ready && !redirect) begin
      model_inst(mpc, e_inst, e_c, len);
      $display("inst pc=%h op=%h c=%0b", inst_pc, inst_out, inst_compressed);
      chk("inst_out", inst_out, e_inst);
      chk("inst_pc", inst_pc, mpc);
      chk("inst_compressed", {31'b0, inst_compressed}, {31'b0, e_c});
      mpc = mpc + 32'(len);
      accepted++;
    end

    if (mem_ack) begin
      pend = 1'b0;
      if (!redirect && req_epoch == epoch) fetch_exp = fetch_exp + 32'd4;
    end
    if (redirect) model_redirect(redirect_pc);

    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_phase();
    rst      = 1'b0;
    mem_ack  = 1'b0;
    redirect = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_inst_out", inst_out, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_inst_compressed", {31'b0, inst_compressed}, 32'd0);
    pend     = 1'b0;
    exp_idle = 1'b0;
    epoch++;
    fetch_exp = 32'd0;
    mpc       = 32'd0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("req_first_cycle", {31'b0, mem_req}, 32'd1);
    chk("addr_first_cycle", mem_addr, 32'd0);
  endtask

  initial begin
    int a0;
    epoch    = 0;
    accepted = 0;
    pend     = 1'b0;
    wcnt     = 0;
    for (int i = 0; i < 1024; i++) img[i] = $urandom;
    img[0]   = 32'h0000_0013;
    img[1]   = 32'h0010_0093;
    img[16]  = 32'h4501_4501;   // 0x040
    img[32]  = 32'h0013_4501;   // 0x080
    img[33]  = 32'h4501_0000;   // 0x084
    img[64]  = 32'h4589_1111;   // 0x100

    // reset and zero-wait start-up
    minlat = 0; maxlat = 0;
    out_ready = 1'b1;
    reset_phase();
    repeat (8) cycle();
    chk("p1_progress", {31'b0, accepted >= 2}, 32'd1);

    // two compressed instructions in one word
    redirect = 1'b1; redirect_pc = 32'h40;
    cycle();
    redirect = 1'b0;
    a0 = accepted;
    repeat (8) cycle();
    chk("p2_progress", {31'b0, (accepted - a0) >= 2}, 32'd1);

    // straddling instruction with slow memory
    minlat = 2; maxlat = 2;
    redirect = 1'b1; redirect_pc = 32'h80;
    cycle();
    redirect = 1'b0;
    a0 = accepted;
    repeat (14) cycle();
    chk("p3_progress", {31'b0, (accepted - a0) >= 2}, 32'd1);

    // back-pressure with zero-wait memory
    minlat = 0; maxlat = 0;
    if (pend) wcnt = 0;
    repeat (4) cycle();
    out_ready = 1'b0;
    repeat (5) cycle();
    begin
      logic [31:0] e_inst;
      logic        e_c;
      int          len;
      model_inst(mpc, e_inst, e_c, len);
      chk("stall_req_low", {31'b0, mem_req}, 32'd0);
      chk("stall_valid", {31'b0, inst_valid}, 32'd1);
      chk("stall_pc", inst_pc, mpc);
      chk("stall_inst", inst_out, e_inst);
    end
    cycle();
    out_ready = 1'b1;
    a0 = accepted;
    repeat (6) cycle();
    chk("p4_progress", {31'b0, accepted > a0}, 32'd1);

    // redirect while a request is outstanding
    minlat = 3; maxlat = 3;
    for (int i = 0; i < 40 && !(mem_req && !pend); i++) cycle();
    chk("p5_req_seen", {31'b0, mem_req && !pend}, 32'd1);
    redirect = 1'b1; redirect_pc = 32'h102;
    cycle();
    redirect = 1'b0;
    a0 = accepted;
    repeat (20) cycle();
    chk("p5_progress", {31'b0, accepted > a0}, 32'd1);

    // redirect coinciding with an ack
    minlat = 0; maxlat = 0;
    if (pend) wcnt = 0;
    for (int i = 0; i < 20 && !mem_req; i++) cycle();
    chk("p6_req_seen", {31'b0, mem_req}, 32'd1);
    redirect = 1'b1; redirect_pc = 32'h200;
    cycle();
    redirect = 1'b0;
    chk("p6_req_next", {31'b0, mem_req}, 32'd1);
    chk("p6_addr_next", mem_addr, 32'h200);
    repeat (8) cycle();

    // randomized traffic
    minlat = 0; maxlat = 3;
    for (int i = 0; i < 800; i++) begin
      out_ready   = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = 32'($urandom_range(0, 4095));
      cycle();
    end
    redirect  = 1'b0;
    out_ready = 1'b1;

    // reset while a fetch is outstanding
    minlat = 5; maxlat = 5;
    for (int i = 0; i < 30 && !pend; i++) cycle();
    chk("p8_pending", {31'b0, pend}, 32'd1);
    reset_phase();
    minlat = 0; maxlat = 2;
    a0 = accepted;
    repeat (20) cycle();
    chk("p8_progress", {31'b0, accepted > a0}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
